// File: rtl/mc_rf_timer.sv
// Refresh-request generator: start/period timer feeding a req/ack refresh handshake
// with a pending-refresh counter. Define MC_RF_POSTPONE_EN for multi-refresh postponement.
module mc_rf_timer #(
    parameter int unsigned CNT_W    = 28,
    parameter int unsigned MAX_PEND = 8
) (
    input  logic             apb_pclk,
    input  logic             apb_prstn,
    input  logic             mc_en,
    input  logic [CNT_W-1:0] mc_rf_start_time_cfg,
    input  logic [CNT_W-1:0] mc_rf_period_time_cfg,
    input  logic             rf_ack,
    output logic             rf_req,
    output logic [3:0]       rf_pend_cnt,
    output logic             rf_urgent,
    output logic             rf_overflow
);

    localparam logic [CNT_W-1:0] CNT_ONES = '1;
`ifdef MC_RF_POSTPONE_EN
    localparam logic [3:0] PEND_CAP = 4'(MAX_PEND);
    localparam logic [3:0] URG_TH   = 4'(MAX_PEND - 1);
`else
    localparam logic [3:0] PEND_CAP = 4'd1;
`endif

    // Elaboration-time guard on the postponement depth
    if (MAX_PEND < 2 || MAX_PEND > 15) begin : g_bad_max_pend
        $error("mc_rf_timer: MAX_PEND out of range 2..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_RUN        = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [CNT_W-1:0] w_period_m1;
    logic             w_tick;
    logic             w_ack;
    logic [3:0]       w_pend_nxt;
    logic             w_ovf_set;
    logic             w_urg_nxt;

    // Effective period is at least 2, so the terminal count is at least 1
    assign w_period_m1 = (mc_rf_period_time_cfg < CNT_W'(2)) ? CNT_W'(1)
                                                             : mc_rf_period_time_cfg - CNT_W'(1);

    assign w_tick = ((r_state == ST_WAIT_START) && (mc_rf_start_time_cfg != CNT_ONES)
                     && (r_cnt >= mc_rf_start_time_cfg))
                 || ((r_state == ST_RUN) && (r_cnt >= w_period_m1));

    assign w_ack = rf_ack & rf_req;

    always_comb begin
        w_pend_nxt = rf_pend_cnt;
        w_ovf_set  = 1'b0;
        if (w_tick && !w_ack) begin
            if (rf_pend_cnt >= PEND_CAP) begin
                w_ovf_set = 1'b1;
            end else begin
                w_pend_nxt = rf_pend_cnt + 4'd1;
            end
        end else if (w_ack && !w_tick) begin
            w_pend_nxt = rf_pend_cnt - 4'd1;
        end
    end

`ifdef MC_RF_POSTPONE_EN
    assign w_urg_nxt = (w_pend_nxt >= URG_TH);
`else
    assign w_urg_nxt = 1'b0;
`endif

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            rf_pend_cnt <= 4'd0;
            rf_req      <= 1'b0;
            rf_urgent   <= 1'b0;
            rf_overflow <= 1'b0;
        end else if (!mc_en) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            rf_pend_cnt <= 4'd0;
            rf_req      <= 1'b0;
            rf_urgent   <= 1'b0;
            rf_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_WAIT_START;
                    r_cnt   <= '0;
                end
                ST_WAIT_START: begin
                    if (w_tick) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else if (r_cnt != CNT_ONES) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
            rf_pend_cnt <= w_pend_nxt;
            rf_req      <= (w_pend_nxt != 4'd0);
            rf_urgent   <= w_urg_nxt;
            rf_overflow <= rf_overflow | w_ovf_set;
        end
    end

endmodule

// File: tb/tb_mc_rf_timer.sv
// Directed bench for mc_rf_timer; builds with or without MC_RF_POSTPONE_EN.
module tb_mc_rf_timer;

    localparam int unsigned CNT_W = 28;

    logic             clk;
    logic             rst_n;
    logic             mc_en;
    logic [CNT_W-1:0] start_cfg;
    logic [CNT_W-1:0] period_cfg;
    logic             rf_ack;
    logic             rf_req;
    logic [3:0]       rf_pend_cnt;
    logic             rf_urgent;
    logic             rf_overflow;

    int n_chk  = 0;
    int n_pass = 0;

    mc_rf_timer #(.CNT_W(CNT_W), .MAX_PEND(8)) dut (
        .apb_pclk              (clk),
        .apb_prstn             (rst_n),
        .mc_en                 (mc_en),
        .mc_rf_start_time_cfg  (start_cfg),
        .mc_rf_period_time_cfg (period_cfg),
        .rf_ack                (rf_ack),
        .rf_req                (rf_req),
        .rf_pend_cnt           (rf_pend_cnt),
        .rf_urgent             (rf_urgent),
        .rf_overflow           (rf_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req"}, 32'(rf_req), 32'd0);
        chk({tag, "_pend"}, 32'(rf_pend_cnt), 32'd0);
        chk({tag, "_urg"}, 32'(rf_urgent), 32'd0);
        chk({tag, "_ovf"}, 32'(rf_overflow), 32'd0);
    endtask

    initial begin
        logic seen;
        int   exp_pend;
        rst_n      = 1'b0;
        mc_en      = 1'b0;
        rf_ack     = 1'b0;
        start_cfg  = CNT_W'(10);
        period_cfg = CNT_W'(20);
        #12;
        chk_idle("reset");
        #10 rst_n = 1'b1;
        cyc(1);

        // start=10, period=20: ticks at E11, E31, E51
        mc_en = 1'b1;
        cyc(1);
        cyc(10);
        chk("t1_e10_req", 32'(rf_req), 32'd0);
        cyc(1);
        chk("t1_e11_req", 32'(rf_req), 32'd1);
        chk("t1_e11_pend", 32'(rf_pend_cnt), 32'd1);
        rf_ack = 1'b1;
        cyc(1);
        rf_ack = 1'b0;
        chk("t1_e12_req", 32'(rf_req), 32'd0);
        cyc(18);
        chk("t1_e30_req", 32'(rf_req), 32'd0);
        cyc(1);
        chk("t1_e31_req", 32'(rf_req), 32'd1);
        rf_ack = 1'b1;
        cyc(1);
        rf_ack = 1'b0;
        chk("t1_e32_req", 32'(rf_req), 32'd0);
        cyc(18);
        chk("t1_e50_req", 32'(rf_req), 32'd0);
        cyc(1);
        chk("t1_e51_req", 32'(rf_req), 32'd1);

        // Disable with a request outstanding clears everything
        mc_en = 1'b0;
        cyc(1);
        chk_idle("drop1");

        // All-ones start time never ticks
        start_cfg = '1;
        mc_en     = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            cyc(1);
            seen = seen | rf_req | (rf_pend_cnt != 4'd0);
        end
        chk("t2_never_req", 32'(seen), 32'd0);
        mc_en = 1'b0;
        cyc(1);

        // Restart honours start anew; period shrink takes effect next edge
        start_cfg  = CNT_W'(3);
        period_cfg = CNT_W'(100);
        mc_en      = 1'b1;
        cyc(1);
        cyc(3);
        chk("t5_e3_req", 32'(rf_req), 32'd0);
        cyc(1);
        chk("t5_e4_req", 32'(rf_req), 32'd1);
        rf_ack = 1'b1;
        cyc(1);
        rf_ack = 1'b0;
        chk("t5_e5_req", 32'(rf_req), 32'd0);
        cyc(49);
        chk("t5_cnt50_req", 32'(rf_req), 32'd0);
        period_cfg = CNT_W'(5);
        cyc(1);
        chk("t5_shrink_req", 32'(rf_req), 32'd1);
        rf_ack = 1'b1;
        cyc(1);
        rf_ack = 1'b0;
        cyc(3);
        chk("t5_p5_pre_req", 32'(rf_req), 32'd0);
        cyc(1);
        chk("t5_p5_req", 32'(rf_req), 32'd1);
        chk("t5_urg", 32'(rf_urgent), 32'd0);
        mc_en = 1'b0;
        cyc(1);
        chk_idle("drop2");

        start_cfg  = '0;
        period_cfg = CNT_W'(4);
        mc_en      = 1'b1;
        cyc(1);
`ifdef MC_RF_POSTPONE_EN
        // Ticks at E1+4k; ack coincides with tick k=3 (pend stays 3)
        for (int k = 0; k < 10; k++) begin
            cyc((k == 0) ? 0 : 3);
            rf_ack = (k == 3);
            cyc(1);
            rf_ack = 1'b0;
            exp_pend = (k < 3) ? k + 1 : ((k > 8) ? 8 : k);
            chk($sformatf("t3_pend_k%0d", k), 32'(rf_pend_cnt), 32'(exp_pend));
            chk($sformatf("t3_urg_k%0d", k), 32'(rf_urgent), 32'(exp_pend >= 7));
            chk($sformatf("t3_ovf_k%0d", k), 32'(rf_overflow), 32'(k == 9));
        end
        period_cfg = CNT_W'(1000);
        rf_ack     = 1'b1;
        cyc(8);
        chk("t3_drain_pend", 32'(rf_pend_cnt), 32'd0);
        chk("t3_drain_req", 32'(rf_req), 32'd0);
        chk("t3_drain_urg", 32'(rf_urgent), 32'd0);
        chk("t3_drain_ovf", 32'(rf_overflow), 32'd1);
        cyc(1);
        rf_ack = 1'b0;
        chk("t4_ack_at0_pend", 32'(rf_pend_cnt), 32'd0);
`else
        cyc(1);
        chk("t6_e1_pend", 32'(rf_pend_cnt), 32'd1);
        chk("t6_e1_ovf", 32'(rf_overflow), 32'd0);
        cyc(3);
        rf_ack = 1'b1;
        cyc(1);
        rf_ack = 1'b0;
        chk("t4_same_edge_pend", 32'(rf_pend_cnt), 32'd1);
        chk("t4_same_edge_ovf", 32'(rf_overflow), 32'd0);
        cyc(4);
        chk("t6_e9_pend", 32'(rf_pend_cnt), 32'd1);
        chk("t6_e9_ovf", 32'(rf_overflow), 32'd1);
        chk("t6_e9_urg", 32'(rf_urgent), 32'd0);
        rf_ack = 1'b1;
        cyc(1);
        chk("t6_e10_pend", 32'(rf_pend_cnt), 32'd0);
        chk("t6_e10_req", 32'(rf_req), 32'd0);
        chk("t6_e10_ovf", 32'(rf_overflow), 32'd1);
        cyc(1);
        rf_ack = 1'b0;
        chk("t4_ack_at0_pend", 32'(rf_pend_cnt), 32'd0);
        cyc(2);
        chk("t6_e13_pend", 32'(rf_pend_cnt), 32'd1);
        chk("t6_e13_ovf", 32'(rf_overflow), 32'd1);
`endif
        mc_en = 1'b0;
        cyc(1);
        chk_idle("drop3");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
